vector_data_memory: RTL and testbench

VECTOR_DATA_MEMORY -- requirements
Module: vector_data_memory

---
 rtl/vector_data_memory_if.sv | 39 +++
 rtl/vector_data_memory.sv | 142 ++++++++++++++
 tb/tb_vector_data_memory.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/vector_data_memory_if.sv
// Bus between the datapath MEM stage and the vector data memory.
// The master drives a request and holds it while Stall is high; the slave
// answers with a one-cycle Done pulse, plus AddrErr for out-of-range requests.
interface vector_data_memory_if #(
  parameter int I = 32,
  parameter int N = 8,
  parameter int R = 6
);
  logic                MemReqM;
  logic                MemWriteM;
  logic [I-1:0]        AddressM;
  logic [R-1:0][N-1:0] WriteDataM;
  logic [R-1:0][N-1:0] ReadData;
  logic                Stall;
  logic                Done;
  logic                AddrErr;

  modport master (
    output MemReqM,
    output MemWriteM,
    output AddressM,
    output WriteDataM,
    input  ReadData,
    input  Stall,
    input  Done,
    input  AddrErr
  );

  modport slave (
    input  MemReqM,
    input  MemWriteM,
    input  AddressM,
    input  WriteDataM,
    output ReadData,
    output Stall,
    output Done,
    output AddrErr
  );
endinterface

// File: rtl/vector_data_memory.sv
// Byte-wide vector data memory. A request moves R lanes, one byte per cycle,
// between the backing store and the datapath. Lane 0 sits at the request
// address and lane k at address+k (little-endian, any alignment). Reads are
// gathered in a hidden buffer so ReadData changes all lanes at once.
module vector_data_memory #(
  parameter int I     = 32,
  parameter int N     = 8,
  parameter int R     = 6,
  parameter int DEPTH = 4096
) (
  input logic                clk,
  input logic                reset,
  vector_data_memory_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (R > 1) ? $clog2(R) : 1;

  // The range check runs one bit wider than the address so it cannot wrap.
  localparam logic [I:0]    LAST_OFFSET = (I+1)'(R - 1);
  localparam logic [I:0]    DEPTH_EXT   = (I+1)'(DEPTH);
  localparam logic [CW-1:0] LAST_LANE   = CW'(R - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    ERR
  } state_t;

  state_t              state_q;
  logic [CW-1:0]       lane_q;
  logic [AW-1:0]       addr_q;
  logic                write_q;
  logic [R-1:0][N-1:0] wdata_q;
  logic [R-1:0][N-1:0] buf_q;
  logic [R-1:0][N-1:0] readData_q;
  logic [R-1:0][N-1:0] readData_d;
  logic                stall_q;
  logic                done_q;
  logic                addrErr_q;

  logic [N-1:0]        mem [DEPTH];

  logic [I:0]          reqLastAddr;
  logic                reqOutOfRange;
  logic [AW-1:0]       memIdx;
  logic [N-1:0]        memRdByte;
  logic [N-1:0]        memWrByte;
  logic                memWrEn;

  assign reqLastAddr   = {1'b0, bus.AddressM} + LAST_OFFSET;
  assign reqOutOfRange = (reqLastAddr >= DEPTH_EXT);

  assign memIdx    = addr_q + AW'(lane_q);
  assign memRdByte = mem[memIdx];
  assign memWrByte = wdata_q[lane_q];
  assign memWrEn   = (state_q == ACCESS) && write_q && !reset;

  // Final read image: earlier lanes from the buffer, the last lane straight from memory.
  always_comb begin
    readData_d        = buf_q;
    readData_d[R-1]   = memRdByte;
  end

  // Backing store is never reset; an edge that samples reset performs no write.
  always_ff @(posedge clk) begin
    if (memWrEn) begin
      mem[memIdx] <= memWrByte;
    end
  end

  // Request FSM with registered Stall/Done/AddrErr and the read gather buffer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
      addrErr_q  <= 1'b0;
      readData_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q    <= 1'b0;
          addrErr_q <= 1'b0;
          stall_q   <= 1'b0;
          lane_q    <= '0;
          if (bus.MemReqM) begin
            addr_q  <= bus.AddressM[AW-1:0];
            write_q <= bus.MemWriteM;
            wdata_q <= bus.WriteDataM;
            stall_q <= 1'b1;
            if (reqOutOfRange) begin
              state_q   <= ERR;
              done_q    <= 1'b1;
              addrErr_q <= 1'b1;
            end else begin
              state_q <= ACCESS;
            end
          end
        end

        ACCESS: begin
          if (!write_q) begin
            buf_q[lane_q] <= memRdByte;
          end
          if (lane_q == LAST_LANE) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (!write_q) begin
              readData_q <= readData_d;
            end
          end else begin
            lane_q <= lane_q + CW'(1);
          end
        end

        DONE, ERR: begin
          state_q   <= IDLE;
          stall_q   <= 1'b0;
          done_q    <= 1'b0;
          addrErr_q <= 1'b0;
          lane_q    <= '0;
        end

        default: begin
          state_q <= IDLE;
          stall_q <= 1'b0;
          done_q  <= 1'b0;
          addrErr_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ReadData = readData_q;
  assign bus.Stall    = stall_q;
  assign bus.Done     = done_q;
  assign bus.AddrErr  = addrErr_q;

endmodule

// File: tb/tb_vector_data_memory.sv
// Directed bench for vector_data_memory: write/read, unaligned access,
// address-range boundaries, reset during a write and ignored requests.
module tb_vector_data_memory;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  vector_data_memory_if #(.I(32), .N(8), .R(6)) bus ();

  vector_data_memory #(.I(32), .N(8), .R(6), .DEPTH(4096)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // 10 ns free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counted, and reported on failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one request held until Done, then observes one more idle cycle.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [47:0] data,
                               output int stallCnt, output int doneCnt, output logic errAtDone,
                               output logic [47:0] rdAtDone, output logic rdStable);
    logic [47:0] rdBefore;
    bit finished;
    @(negedge clk);
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = wr;
    bus.AddressM   = addr;
    bus.WriteDataM = data;
    rdBefore  = bus.ReadData;
    stallCnt  = 0;
    doneCnt   = 0;
    errAtDone = 1'b0;
    rdAtDone  = '0;
    rdStable  = 1'b1;
    finished  = 0;
    for (int c = 0; c < 20 && !finished; c++) begin
      @(negedge clk);
      if (bus.Stall) stallCnt++;
      if (bus.Done) begin
        doneCnt++;
        errAtDone   = bus.AddrErr;
        rdAtDone    = bus.ReadData;
        bus.MemReqM = 1'b0;
        finished    = 1;
      end else if (bus.ReadData !== rdBefore) begin
        rdStable = 1'b0;
      end
    end
    bus.MemReqM = 1'b0;
    @(negedge clk);
    if (bus.Stall) stallCnt++;
    if (bus.Done) doneCnt++;
  endtask

  int          stallCnt;
  int          doneCnt;
  logic        errAtDone;
  logic [47:0] rd;
  logic        rdStable;

  // Linear sequence of directed steps.
  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.MemReqM    = 1'b0;
    bus.MemWriteM  = 1'b0;
    bus.AddressM   = '0;
    bus.WriteDataM = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_stall", 64'(bus.Stall), 64'd0);
    checkOutput("reset_done", 64'(bus.Done), 64'd0);
    checkOutput("reset_err", 64'(bus.AddrErr), 64'd0);
    checkOutput("reset_rdata", 64'(bus.ReadData), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] write 01..06 at 0x100");
    applyStimulus(1'b1, 32'h100, 48'h060504030201, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("wr100_stall", 64'(stallCnt), 64'd7);
    checkOutput("wr100_done", 64'(doneCnt), 64'd1);
    checkOutput("wr100_err", 64'(errAtDone), 64'd0);
    checkOutput("wr100_rdata", 64'(rd), 64'd0);

    $display("[TB] read 0x100");
    applyStimulus(1'b0, 32'h100, 48'h0, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("rd100_stall", 64'(stallCnt), 64'd7);
    checkOutput("rd100_done", 64'(doneCnt), 64'd1);
    checkOutput("rd100_data", 64'(rd), 64'h060504030201);
    checkOutput("rd100_held0", 64'(rdStable), 64'd1);

    $display("[TB] write AA at 0x106, read 0x101");
    applyStimulus(1'b1, 32'h106, 48'h0000000000AA, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("wr106_rdata_kept", 64'(rd), 64'h060504030201);
    applyStimulus(1'b0, 32'h101, 48'h0, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("rd101_data", 64'(rd), 64'hAA0605040302);
    checkOutput("rd101_held", 64'(rdStable), 64'd1);

    $display("[TB] boundary 0xFFA in range");
    applyStimulus(1'b1, 32'hFFA, 48'h5A4B3C2D1E0F, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("wrFFA_err", 64'(errAtDone), 64'd0);
    applyStimulus(1'b0, 32'hFFA, 48'h0, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("rdFFA_stall", 64'(stallCnt), 64'd7);
    checkOutput("rdFFA_err", 64'(errAtDone), 64'd0);
    checkOutput("rdFFA_data", 64'(rd), 64'h5A4B3C2D1E0F);

    $display("[TB] boundary 0xFFB out of range");
    applyStimulus(1'b1, 32'hFFB, 48'hFFFFFFFFFFFF, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("wrFFB_stall", 64'(stallCnt), 64'd1);
    checkOutput("wrFFB_done", 64'(doneCnt), 64'd1);
    checkOutput("wrFFB_err", 64'(errAtDone), 64'd1);
    checkOutput("wrFFB_rdata", 64'(rd), 64'h5A4B3C2D1E0F);
    applyStimulus(1'b0, 32'hFFA, 48'h0, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("rdFFA_after_err", 64'(rd), 64'h5A4B3C2D1E0F);

    $display("[TB] top-of-address-space request");
    applyStimulus(1'b0, 32'hFFFFFFFF, 48'h0, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("rdTop_stall", 64'(stallCnt), 64'd1);
    checkOutput("rdTop_err", 64'(errAtDone), 64'd1);
    checkOutput("rdTop_rdata", 64'(rd), 64'h5A4B3C2D1E0F);

    $display("[TB] reset during write at 0x200");
    applyStimulus(1'b1, 32'h200, 48'h0, stallCnt, doneCnt, errAtDone, rd, rdStable);
    @(negedge clk);
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = 1'b1;
    bus.AddressM   = 32'h200;
    bus.WriteDataM = 48'h161514131211;
    @(negedge clk);
    bus.MemReqM = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("abort_in_access", 64'(bus.Stall), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("abort_stall", 64'(bus.Stall), 64'd0);
    checkOutput("abort_done", 64'(bus.Done), 64'd0);
    checkOutput("abort_rdata", 64'(bus.ReadData), 64'd0);
    doneCnt = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.Done) doneCnt++;
    end
    checkOutput("abort_no_done", 64'(doneCnt), 64'd0);
    applyStimulus(1'b0, 32'h200, 48'h0, stallCnt, doneCnt, errAtDone, rd, rdStable);
    checkOutput("rd200_partial", 64'(rd), 64'h000000131211);

    $display("[TB] request pulse while stalled");
    @(negedge clk);
    bus.MemReqM   = 1'b1;
    bus.MemWriteM = 1'b0;
    bus.AddressM  = 32'h100;
    @(negedge clk);
    bus.MemReqM = 1'b0;
    @(negedge clk);
    bus.MemReqM  = 1'b1;
    bus.AddressM = 32'h200;
    @(negedge clk);
    bus.MemReqM = 1'b0;
    doneCnt = 0;
    rd = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.Done) begin
        doneCnt++;
        rd = bus.ReadData;
      end
    end
    checkOutput("pulse_done_count", 64'(doneCnt), 64'd1);
    checkOutput("pulse_rdata", 64'(rd), 64'h060504030201);
    checkOutput("pulse_idle", 64'(bus.Stall), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
